// File: rtl/lfsr_encrypt.sv
// Stream encrypter: writes a '_' preamble followed by message bytes to mem[64..127].
// Each byte's low six bits are XORed with a 6-bit Fibonacci LFSR keystream.
module lfsr_encrypt (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  input  logic [2:0] tap_sel,
  input  logic [5:0] seed,
  input  logic [3:0] pre_len,
  output logic [7:0] raddr,
  input  logic [7:0] data_out,
  output logic [7:0] waddr,
  output logic [7:0] data_in,
  output logic       wr_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h5F;
  localparam logic [7:0] OUT_BASE      = 8'd64;
  localparam logic [6:0] LAST_K        = 7'd63;

  state_t     r_state;
  state_t     w_state_next;
  logic [6:0] r_k;
  logic [5:0] r_lfsr;
  logic [5:0] r_taps;
  logic [3:0] r_pre_len;
  logic       r_err;

  logic [5:0] w_tap_lut;
  logic       w_legal;
  logic       w_accept;
  logic       w_reject;
  logic       w_in_preamble;
  logic [7:0] w_plain;
  logic [5:0] w_lfsr_next;

  always_comb begin
    w_tap_lut = 6'h21;
    case (tap_sel)
      3'd0:    w_tap_lut = 6'h21;
      3'd1:    w_tap_lut = 6'h2D;
      3'd2:    w_tap_lut = 6'h30;
      3'd3:    w_tap_lut = 6'h33;
      3'd4:    w_tap_lut = 6'h36;
      3'd5:    w_tap_lut = 6'h39;
      default: w_tap_lut = 6'h21;
    endcase
  end

  assign w_legal     = (tap_sel < 3'd6) && (seed != 6'd0) &&
                       (pre_len >= 4'd7) && (pre_len <= 4'd12);
  assign w_lfsr_next = {r_lfsr[4:0], ^(r_lfsr & r_taps)};

  // Next state and all outputs; start is only looked at in IDLE and DONE.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_reject      = 1'b0;
    w_in_preamble = ({3'b000, r_pre_len} > r_k);
    w_plain       = w_in_preamble ? PREAMBLE_BYTE : data_out;
    raddr         = {1'b0, r_k} - {4'b0000, r_pre_len};
    waddr         = OUT_BASE + {1'b0, r_k};
    data_in       = w_plain ^ {2'b00, r_lfsr};
    wr_en         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    err           = r_err;
    case (r_state)
      S_IDLE, S_DONE: begin
        done     = (r_state == S_DONE);
        w_accept = start && w_legal;
        w_reject = start && !w_legal;
        if (w_accept) w_state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        // NOTE: reset is synchronous, so wr_en is gated by init_n to keep the aborting edge from writing.
        wr_en = init_n;
        if (r_k == LAST_K) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!init_n) begin
      r_state   <= S_IDLE;
      r_k       <= 7'd0;
      r_lfsr    <= 6'd0;
      r_taps    <= 6'd0;
      r_pre_len <= 4'd0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_taps    <= w_tap_lut;
        r_lfsr    <= seed;
        r_pre_len <= pre_len;
        r_k       <= 7'd0;
        r_err     <= 1'b0;
      end else if (w_reject) begin
        r_err <= 1'b1;
      end else if (r_state == S_RUN) begin
        r_lfsr <= w_lfsr_next;
        r_k    <= r_k + 7'd1;
      end
    end
  end

endmodule
